fifo_fill_ctrl: RTL and testbench
=================================

# fifo_fill_ctrl

Memory-to-FIFO fill stage for the 8×8 matrix-vector engine. It sits between `mem_wrapper` (Avalon-MM read master side) and the nine input FIFOs: the B-vector FIFO plus one FIFO per A-matrix row. On `start` it fetches nine 64-bit words, one per row, unpacks each into eight 8-bit elements, and writes them byte-serially into the owning FIFO. It then pulses `done` so the compute controller can begin the pre-read/MAC phase.

## Interface
Parameters:
- `DATA_WIDTH`, 8: element width; `BYTES_PER_WORD` is derived as 64/DATA_WIDTH.
- `NUM_FIFOS`, 9: FIFO 0 is B; FIFOs 1..8 are A rows 0..7.
- `BASE_ADDR`, 32'h0: word address of row 0 (the B vector).

Ports:
- `clk`  in  1  system clock; all logic is on its rising edge.
- `rst_n`  in  1  asynchronous active-low reset.
- `start`  in  1  one-cycle request to begin a fill; ignored unless idle.
- `mem_address`  out  32  word address presented to `mem_wrapper`.
- `mem_read`  out  1  Avalon read request.
- `mem_readdata`  in  64  read data.
- `mem_readdatavalid`  in  1  read data qualifier.
- `mem_waitrequest`  in  1  slave stall; a read is accepted on a cycle where `mem_read`=1 and `mem_waitrequest`=0.
- `fifo_data`  out  DATA_WIDTH  element bus shared by all FIFOs.
- `fifo_wrreq`  out  NUM_FIFOS  one-hot write strobe; bit r targets FIFO r.
- `fifo_wrfull`  in  NUM_FIFOS  full flags from the FIFOs.
- `busy`  out  1  high from the cycle after an accepted `start` until `done`.
- `done`  out  1  one-cycle pulse after the last byte of FIFO 8 is written.

## Operation
- FSM states: IDLE, REQ, WAIT, UNPACK, DONE.
- IDLE: if `start`=1, clear row=0 and byte=0, then go to REQ.
- REQ: drive `mem_read`=1 and `mem_address`=BASE_ADDR+row. Hold both stable while `mem_waitrequest`=1. On acceptance, go to WAIT.
- WAIT: `mem_read`=0. On `mem_readdatavalid`, latch `mem_readdata` into the word register and go to UNPACK.
- UNPACK: present byte k = word[8k+7:8k], least-significant byte first, with k=0..7.
  - Assert `fifo_wrreq[row]` only when `fifo_wrfull[row]`=0.
  - If that FIFO is full, stall: hold k and drive `fifo_wrreq`=0.
  - After k=7 is written: if row=8 go to DONE; otherwise row++ and go to REQ.
- DONE: `done`=1 for one cycle, then go to IDLE.
- Only one read is outstanding at a time.
- `mem_readdatavalid` outside WAIT is ignored and does not disturb state.
- `start` is ignored in every state except IDLE.
- `fifo_wrreq` is always one-hot or zero. It never targets a row other than the current one.
- Reset (asynchronous, any state):
  - FSM returns to IDLE; row, byte, and the word register clear to 0.
  - Outputs clear: `mem_read`=0, `mem_address`=BASE_ADDR, `fifo_wrreq`=0, `fifo_data`=0, `busy`=0, `done`=0.
  - FIFO contents are not touched by this block; they are cleared by their own aclr.

## Timing
- `start` sampled at edge T: `mem_read`=1 from T+1. All control outputs are registered.
- Data latched on the `mem_readdatavalid` edge: first `fifo_wrreq` is visible the next cycle.
- In UNPACK, `fifo_data` and `fifo_wrreq` change together, once per unstalled cycle.
- `mem_readdatavalid` must arrive at least one cycle after acceptance.
- Best case per row, with no waitrequest, 1-cycle read latency, and no full FIFOs: 1 REQ + 1 WAIT + 8 UNPACK = 10 cycles.
- Full fill: `done` at T+91.
- Each waitrequest cycle, each extra cycle of read latency, and each full-stall cycle adds exactly one cycle.

## Structure
- Package `fill_pkg`:
  - `fill_state_t` enum.
  - `NUM_FIFOS`, `BYTES_PER_WORD`, `ROW_B`=0, `ROW_A0`=1.
  - Shared with the compute controller, which uses the same row mapping.
- Sub-module `word_unpacker`:
  - 64-bit load/shift register.
  - Inputs `load` and `advance`.
  - Outputs the current byte and a `last` flag at k=7.
- Top `fifo_fill_ctrl` holds the FSM, row counter, address generation, and one-hot strobe decode.

## Test plan
- Basic fill: memory word r = {8{8'(r*16)}} + 64'h0706050403020100; pulse `start`. FIFO r must receive bytes 00+16r … 07+16r in order; `done` pulses at T+91; 72 writes total.
- Waitrequest: hold `mem_waitrequest`=1 for 3 cycles on row 4. `mem_address` stays at 4 with `mem_read` high; `done` moves to T+94.
- Full stall: assert `fifo_wrfull[2]` for 5 cycles during byte 3 of row 2. No write occurs in those cycles; byte 3 is written once after release; `done` moves to T+96.
- Spurious inputs: pulse `start` mid-fill and inject `mem_readdatavalid` with data FF…FF during REQ. Both are ignored; FIFO contents match the basic fill exactly.
- Reset mid-UNPACK of row 5: all outputs are 0 the same cycle. A subsequent `start` refetches from address 0 and completes in 91 cycles.

Source files
------------

// File: rtl/fill_pkg.sv
// Shared definitions for the matrix-vector engine fill path.
// The compute controller relies on the same row-to-FIFO mapping.
package fill_pkg;

  localparam int unsigned NUM_FIFOS      = 9;
  localparam int unsigned WORD_WIDTH     = 64;
  localparam int unsigned BYTES_PER_WORD = WORD_WIDTH / 8;
  localparam int unsigned ROW_B          = 0;
  localparam int unsigned ROW_A0         = 1;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_UNPACK,
    ST_DONE
  } fill_state_t;

endpackage

// File: rtl/word_unpacker.sv
// Holds one fetched memory word and walks it least-significant element first.
module word_unpacker #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned BYTES_PER_WORD = 8
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 clear,
  input  logic                                 load,
  input  logic [DATA_WIDTH*BYTES_PER_WORD-1:0] word_in,
  input  logic                                 advance,
  output logic [DATA_WIDTH-1:0]                cur_byte,
  output logic                                 last
);
  import fill_pkg::*;

  localparam int unsigned WORD_W = DATA_WIDTH * BYTES_PER_WORD;
  localparam int unsigned K_W    = $clog2(BYTES_PER_WORD);

  logic [WORD_W-1:0] word_q;
  logic [K_W-1:0]    k_q;

  // last is kept as a flop so the FSM sees it alongside the element it flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
      k_q    <= '0;
      last   <= 1'b0;
    end else if (clear) begin
      k_q    <= '0;
      last   <= 1'b0;
    end else if (load) begin
      word_q <= word_in;
      k_q    <= '0;
      last   <= 1'b0;
    end else if (advance) begin
      word_q <= word_q >> DATA_WIDTH;
      k_q    <= k_q + K_W'(1);
      last   <= (k_q == K_W'(BYTES_PER_WORD - 2));
    end
  end

  assign cur_byte = word_q[DATA_WIDTH-1:0];

endmodule

// File: rtl/fifo_fill_ctrl.sv
// Fetches one 64-bit word per row and streams its elements into the owning FIFO.
// Row 0 feeds the B-vector FIFO, rows 1..8 feed the A-matrix row FIFOs.
module fifo_fill_ctrl #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned NUM_FIFOS  = 9,
  parameter logic [31:0] BASE_ADDR  = 32'h0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  output logic [31:0]           mem_address,
  output logic                  mem_read,
  input  logic [63:0]           mem_readdata,
  input  logic                  mem_readdatavalid,
  input  logic                  mem_waitrequest,
  output logic [DATA_WIDTH-1:0] fifo_data,
  output logic [NUM_FIFOS-1:0]  fifo_wrreq,
  input  logic [NUM_FIFOS-1:0]  fifo_wrfull,
  output logic                  busy,
  output logic                  done
);
  import fill_pkg::*;

  localparam int unsigned BYTES_PER_WORD = 64 / DATA_WIDTH;
  localparam int unsigned ROW_W          = $clog2(NUM_FIFOS);
  localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(NUM_FIFOS - 1);

  fill_state_t state_q, state_d;
  logic [ROW_W-1:0]      row_q, row_d;
  logic                  mem_read_d;
  logic [31:0]           mem_address_d;
  logic [NUM_FIFOS-1:0]  fifo_wrreq_d;
  logic [DATA_WIDTH-1:0] fifo_data_d;
  logic                  busy_d;
  logic                  done_d;
  logic                  clear_c;
  logic                  load_c;
  logic                  advance_c;
  logic [DATA_WIDTH-1:0] cur_byte;
  logic                  last;

  word_unpacker #(
    .DATA_WIDTH     (DATA_WIDTH),
    .BYTES_PER_WORD (BYTES_PER_WORD)
  ) u_unpack (
    .clk      (clk),
    .rst_n    (rst_n),
    .clear    (clear_c),
    .load     (load_c),
    .word_in  (mem_readdata),
    .advance  (advance_c),
    .cur_byte (cur_byte),
    .last     (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      row_q       <= ROW_W'(ROW_B);
      mem_read    <= 1'b0;
      mem_address <= BASE_ADDR;
      fifo_wrreq  <= '0;
      fifo_data   <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      mem_read    <= mem_read_d;
      mem_address <= mem_address_d;
      fifo_wrreq  <= fifo_wrreq_d;
      fifo_data   <= fifo_data_d;
      busy        <= busy_d;
      done        <= done_d;
    end
  end

  // Outputs are decoded from the next state so they line up with the state they describe
  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    clear_c      = 1'b0;
    load_c       = 1'b0;
    advance_c    = 1'b0;
    fifo_wrreq_d = '0;
    fifo_data_d  = fifo_data;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          row_d   = ROW_W'(ROW_B);
          clear_c = 1'b1;
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (!mem_waitrequest) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_readdatavalid) begin
          load_c  = 1'b1;
          state_d = ST_UNPACK;
        end
      end
      ST_UNPACK: begin
        // A full target FIFO freezes the element index until space returns
        if (!fifo_wrfull[row_q]) begin
          fifo_wrreq_d = NUM_FIFOS'(1) << row_q;
          fifo_data_d  = cur_byte;
          advance_c    = 1'b1;
          if (last) begin
            if (row_q == LAST_ROW) begin
              state_d = ST_DONE;
            end else begin
              row_d   = row_q + ROW_W'(1);
              state_d = ST_REQ;
            end
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    mem_read_d    = (state_d == ST_REQ);
    mem_address_d = BASE_ADDR + 32'(row_d);
    busy_d        = (state_d == ST_REQ) || (state_d == ST_WAIT) || (state_d == ST_UNPACK);
    done_d        = (state_d == ST_DONE);
  end

endmodule

// File: tb/tb_fifo_fill_ctrl.sv
// Directed bench for fifo_fill_ctrl with a 1-cycle-latency memory model and per-FIFO scoreboards.
module tb_fifo_fill_ctrl;

  localparam int unsigned NF = 9;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [31:0]   mem_address;
  logic          mem_read;
  logic [63:0]   mem_readdata = '0;
  logic          mem_readdatavalid = 1'b0;
  logic          mem_waitrequest = 1'b0;
  logic [7:0]    fifo_data;
  logic [NF-1:0] fifo_wrreq;
  logic [NF-1:0] fifo_wrfull = '0;
  logic          busy;
  logic          done;

  fifo_fill_ctrl #(
    .DATA_WIDTH (8),
    .NUM_FIFOS  (NF),
    .BASE_ADDR  (32'h0)
  ) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .start             (start),
    .mem_address       (mem_address),
    .mem_read          (mem_read),
    .mem_readdata      (mem_readdata),
    .mem_readdatavalid (mem_readdatavalid),
    .mem_waitrequest   (mem_waitrequest),
    .fifo_data         (fifo_data),
    .fifo_wrreq        (fifo_wrreq),
    .fifo_wrfull       (fifo_wrfull),
    .busy              (busy),
    .done              (done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;
  int write_cnt = 0;
  int stall_addr = -1;
  int stall_left = 0;
  int spur_addr = -1;
  logic [7:0] fifo_q [NF][$];
  logic        acc;
  logic [31:0] acc_addr;

  function automatic logic [63:0] mem_word(input int a);
    logic [63:0] w;
    for (int k = 0; k < 8; k++) w[8*k +: 8] = 8'(16 * a + k);
    return w;
  endfunction

  // Memory slave: answers an accepted read one cycle later, optional stalls and spurious valid
  always @(posedge clk) begin
    acc      = mem_read && !mem_waitrequest && rst_n;
    acc_addr = mem_address;
    #1;
    mem_readdatavalid = 1'b0;
    mem_readdata      = '0;
    if (acc) begin
      mem_readdatavalid = 1'b1;
      mem_readdata      = mem_word(int'(acc_addr));
    end else if (mem_read && int'(mem_address) == spur_addr) begin
      mem_readdatavalid = 1'b1;
      mem_readdata      = '1;
      spur_addr         = -1;
    end
    mem_waitrequest = 1'b0;
    if (mem_read && stall_left > 0 && int'(mem_address) == stall_addr) begin
      mem_waitrequest = 1'b1;
      stall_left--;
    end
  end

  // FIFO-side capture: every strobe is one write into the addressed FIFO
  always @(negedge clk) begin
    if (rst_n && fifo_wrreq != '0) begin
      checks++;
      if ($countones(fifo_wrreq) != 1)
        $display("FAIL onehot: wrreq=%b expected a single bit", fifo_wrreq);
      else
        passed++;
      for (int i = 0; i < NF; i++)
        if (fifo_wrreq[i]) fifo_q[i].push_back(fifo_data);
      write_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic clear_scoreboard();
    for (int i = 0; i < NF; i++) fifo_q[i].delete();
    write_cnt = 0;
  endtask

  task automatic check_contents(input string tag);
    logic [63:0] got;
    for (int r = 0; r < NF; r++) begin
      got = '0;
      for (int k = 0; k < fifo_q[r].size() && k < 8; k++) got[8*k +: 8] = fifo_q[r][k];
      checks++;
      if (fifo_q[r].size() != 8 || got !== mem_word(r))
        $display("FAIL %s fifo%0d: got %0d bytes %h expected 8 bytes %h",
                 tag, r, fifo_q[r].size(), got, mem_word(r));
      else
        passed++;
    end
    checks++;
    if (write_cnt != 72) $display("FAIL %s writes: got %0d expected 72", tag, write_cnt);
    else passed++;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick();
    tick();
    checks++;
    if ({mem_read, busy, done} !== 3'b000)
      $display("FAIL reset ctrl: got %b expected 000", {mem_read, busy, done});
    else passed++;
    checks++;
    if (mem_address !== 32'h0) $display("FAIL reset addr: got %h expected 0", mem_address);
    else passed++;
    checks++;
    if ({fifo_wrreq, fifo_data} !== 17'h0)
      $display("FAIL reset fifo: got %h/%h expected 0/0", fifo_wrreq, fifo_data);
    else passed++;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic_fill();
    int n;
    clear_scoreboard();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    checks++;
    if ({mem_read, busy, mem_address} !== {2'b11, 32'h0})
      $display("FAIL basic first_req: got rd=%b busy=%b addr=%h expected 1 1 0", mem_read, busy, mem_address);
    else passed++;
    while (done !== 1'b1 && n < 400) begin
      tick();
      n++;
      if (n == 2) begin
        checks++;
        if (mem_read !== 1'b0) $display("FAIL basic wait_rd: got %b expected 0", mem_read);
        else passed++;
      end
      if (n == 4) begin
        checks++;
        if ({fifo_wrreq, fifo_data} !== {9'h001, 8'h00})
          $display("FAIL basic first_write: got %h/%h expected 001/00", fifo_wrreq, fifo_data);
        else passed++;
      end
      if (n == 5) begin
        checks++;
        if (fifo_data !== 8'h01) $display("FAIL basic second_byte: got %h expected 01", fifo_data);
        else passed++;
      end
      if (n == 11) begin
        checks++;
        if ({mem_read, mem_address} !== {1'b1, 32'h1})
          $display("FAIL basic row1_req: got rd=%b addr=%h expected 1 1", mem_read, mem_address);
        else passed++;
      end
    end
    checks++;
    if (n != 91) $display("FAIL basic done_latency: got %0d expected 91", n);
    else passed++;
    checks++;
    if ({fifo_wrreq, fifo_data} !== {9'h100, 8'h87})
      $display("FAIL basic last_write: got %h/%h expected 100/87", fifo_wrreq, fifo_data);
    else passed++;
    tick();
    checks++;
    if ({done, busy} !== 2'b00) $display("FAIL basic done_pulse: got %b expected 00", {done, busy});
    else passed++;
    check_contents("basic");
  endtask

  task automatic test_waitrequest();
    int n;
    clear_scoreboard();
    stall_addr = 4;
    stall_left = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 400) begin
      tick();
      n++;
      if (n >= 41 && n <= 44) begin
        checks++;
        if ({mem_read, mem_address} !== {1'b1, 32'h4})
          $display("FAIL waitreq hold@%0d: got rd=%b addr=%h expected 1 4", n, mem_read, mem_address);
        else passed++;
      end
      if (n == 45) begin
        checks++;
        if (mem_read !== 1'b0) $display("FAIL waitreq release: got %b expected 0", mem_read);
        else passed++;
      end
    end
    checks++;
    if (n != 94) $display("FAIL waitreq done_latency: got %0d expected 94", n);
    else passed++;
    tick();
    check_contents("waitreq");
    stall_addr = -1;
  endtask

  task automatic test_full_stall();
    int n;
    clear_scoreboard();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 400) begin
      tick();
      n++;
      if (n == 26) fifo_wrfull[2] = 1'b1;
      if (n == 31) fifo_wrfull[2] = 1'b0;
      if (n >= 27 && n <= 31) begin
        checks++;
        if (fifo_wrreq !== '0) $display("FAIL full stall@%0d: got wrreq %b expected 0", n, fifo_wrreq);
        else passed++;
      end
      if (n == 32) begin
        checks++;
        if ({fifo_wrreq, fifo_data} !== {9'h004, 8'h23})
          $display("FAIL full resume: got %h/%h expected 004/23", fifo_wrreq, fifo_data);
        else passed++;
      end
    end
    checks++;
    if (n != 96) $display("FAIL full done_latency: got %0d expected 96", n);
    else passed++;
    tick();
    check_contents("full");
  endtask

  task automatic test_spurious();
    int n;
    clear_scoreboard();
    spur_addr = 3;
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (done !== 1'b1 && n < 400) begin
      tick();
      n++;
      if (n == 15) start = 1'b1;
      if (n == 16) begin
        start = 1'b0;
        checks++;
        if (busy !== 1'b1) $display("FAIL spurious busy: got %b expected 1", busy);
        else passed++;
      end
    end
    checks++;
    if (n != 91) $display("FAIL spurious done_latency: got %0d expected 91", n);
    else passed++;
    tick();
    check_contents("spurious");
    spur_addr = -1;
  endtask

  task automatic test_reset_mid_unpack();
    int n;
    clear_scoreboard();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    while (n < 55) begin
      tick();
      n++;
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({mem_read, busy, done} !== 3'b000)
      $display("FAIL midrst ctrl: got %b expected 000", {mem_read, busy, done});
    else passed++;
    checks++;
    if (mem_address !== 32'h0) $display("FAIL midrst addr: got %h expected 0", mem_address);
    else passed++;
    checks++;
    if ({fifo_wrreq, fifo_data} !== 17'h0)
      $display("FAIL midrst fifo: got %h/%h expected 0/0", fifo_wrreq, fifo_data);
    else passed++;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    clear_scoreboard();
    start = 1'b1;
    tick();
    start = 1'b0;
    n = 1;
    checks++;
    if ({mem_read, mem_address} !== {1'b1, 32'h0})
      $display("FAIL midrst refetch: got rd=%b addr=%h expected 1 0", mem_read, mem_address);
    else passed++;
    while (done !== 1'b1 && n < 400) begin
      tick();
      n++;
    end
    checks++;
    if (n != 91) $display("FAIL midrst done_latency: got %0d expected 91", n);
    else passed++;
    tick();
    check_contents("midrst");
  endtask

  initial begin
    test_reset();
    test_basic_fill();
    test_waitrequest();
    test_full_stall();
    test_spurious();
    test_reset_mid_unpack();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
